// File: rtl/add_sequencer.sv
// ---------------------------------------------------------------------------
// add_sequencer
//   Multi-precision add/subtract controller. Latches two WORDS*8-bit operands
//   and pushes one 8-bit slice per cycle (LS slice first) through a single
//   shared 8-bit ripple-carry adder. The carry is held in a register between
//   slices. The full result is returned under a start/done handshake.
//
// Ports
//   clk_i    in   1  clock, all state changes on the rising edge
//   rst_i    in   1  synchronous active-high reset
//   start_i  in   1  request, sampled only in IDLE
//   sub_i    in   1  0 = A+B, 1 = A-B, latched with the operands
//   a_i      in   W  operand A
//   b_i      in   W  operand B
//   busy_o   out  1  high while not IDLE
//   done_o   out  1  one-cycle result-valid pulse
//   sum_o    out  W  result, held from done until the next accept
//   cout_o   out  1  carry out of the MS slice (sub: 1 = no borrow)
//   ovf_o    out  1  two's-complement overflow of the W-bit operation
//
// State table
//   IDLE | waiting for start, operands not latched
//   RUN  | one slice per cycle through the shared adder
//   DONE | result valid for exactly one cycle
// ---------------------------------------------------------------------------

// 8-bit ripple-carry slice adder; bit 0 is the LSB and takes the carry-in.
module ripple_carry #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o
);
    logic [N:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = carry[N];
endmodule

module add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 sub_i,
    input  logic [8*WORDS-1:0]   a_i,
    input  logic [8*WORDS-1:0]   b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [8*WORDS-1:0]   sum_o,
    output logic                 cout_o,
    output logic                 ovf_o
);
    localparam int W  = 8 * WORDS;
    // Slice index needs at least one bit even when there is a single slice.
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sub_q, sub_d;
    logic          carry_q, carry_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  b_eff;
    logic [7:0]    a_slice;
    logic [7:0]    b_slice;
    logic [7:0]    s_slice;
    logic          c_slice;
    logic          accept;
    logic          last_slice;

    // Subtraction is a + ~b + 1; the +1 comes from carry_q being preset to sub.
    assign b_eff      = sub_q ? ~b_q : b_q;
    assign accept     = (state_q == IDLE) && start_i;
    assign last_slice = (k_q == K_LAST);

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k_q == KW'(i)) begin
                a_slice = a_q[8*i +: 8];
                b_slice = b_eff[8*i +: 8];
            end
        end
    end

    ripple_carry #(.N(8)) u_adder (
        .a_i (a_slice),
        .b_i (b_slice),
        .c_i (carry_q),
        .s_o (s_slice),
        .c_o (c_slice)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i)    state_d = RUN;
            RUN:  if (last_slice) state_d = DONE;
            DONE:                 state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

    // -----------------------------------------------------------------------
    // Datapath next-state
    // -----------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (accept) begin
            a_d     = a_i;
            b_d     = b_i;
            sub_d   = sub_i;
            carry_d = sub_i;
            k_d     = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (k_q == KW'(i)) begin
                    sum_d[8*i +: 8] = s_slice;
                end
            end
            carry_d = c_slice;
            if (last_slice) begin
                cout_d = c_slice;
                ovf_d  = (a_q[W-1] == b_eff[W-1]) && (s_slice[7] != a_q[W-1]);
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
